// File: rtl/new_aes128_core.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly key expansion.
// Optional macro AES_DONE_PULSE_EN adds a one-cycle done_o pulse on completion.
module new_aes128_core #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [127:0] key_i,
    input  logic [127:0] data_i,
    output logic [127:0] data_o,
    output logic         busy_o
`ifdef AES_DONE_PULSE_EN
    ,
    output logic         done_o
`endif
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        int idx;
        idx = 8 * (255 - int'(x));
        return SBOX[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_data;
    logic [127:0] r_key;
    logic [3:0]   r_ctr;
    logic         w_load;
    logic         w_round;
    logic         w_last;
    logic [7:0]   w_sb [16];
    logic [7:0]   w_sr [16];
    logic [7:0]   w_mc [16];
    logic [127:0] w_round_out;
    logic [31:0]  w_rot;
    logic [31:0]  w_tmp;
    logic [127:0] w_key_nxt;

    assign w_last = (r_ctr == 4'(NUM_ROUNDS));

    always_ff @(posedge clk) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_round     = 1'b0;
        case (r_state)
            ST_IDLE: if (load_i) begin
                w_load      = 1'b1;
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                w_round = 1'b1;
                if (w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Byte i of the state sits at row i%4, column i/4; byte 0 is the top byte.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_sb[i] = sbox(r_data[127 - 8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[4*c + r] = w_sb[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[4*c + 0] = xtime(w_sr[4*c+0]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c + 1] = w_sr[4*c+0] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c + 2] = w_sr[4*c+0] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
            w_mc[4*c + 3] = xtime(w_sr[4*c+0]) ^ w_sr[4*c+0] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
        end
        w_round_out = '0;
        for (int i = 0; i < 16; i++) begin
            w_round_out[127 - 8*i -: 8] = w_last ? w_sr[i] : w_mc[i];
        end
    end

    always_comb begin
        w_rot = {r_key[23:0], r_key[31:24]};
        w_tmp = {sbox(w_rot[31:24]) ^ rcon(r_ctr), sbox(w_rot[23:16]),
                 sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_key_nxt[127:96] = r_key[127:96] ^ w_tmp;
        w_key_nxt[95:64]  = r_key[95:64]  ^ w_key_nxt[127:96];
        w_key_nxt[63:32]  = r_key[63:32]  ^ w_key_nxt[95:64];
        w_key_nxt[31:0]   = r_key[31:0]   ^ w_key_nxt[63:32];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_data <= '0;
            r_key  <= '0;
            r_ctr  <= '0;
        end else if (w_load) begin
            r_data <= data_i ^ key_i;
            r_key  <= key_i;
            r_ctr  <= 4'd1;
        end else if (w_round) begin
            r_data <= w_round_out ^ w_key_nxt;
            r_key  <= w_key_nxt;
            r_ctr  <= w_last ? 4'd0 : r_ctr + 4'd1;
        end
    end

    assign data_o = r_data;
    assign busy_o = (r_state == ST_BUSY);

`ifdef AES_DONE_PULSE_EN
    logic r_done;

    always_ff @(posedge clk) begin
        if (rst_i) r_done <= 1'b0;
        else       r_done <= w_round && w_last;
    end

    assign done_o = r_done;
`endif

endmodule

// File: tb/tb_new_aes128_core.sv
// Directed bench for new_aes128_core with a scoreboard of expected ciphertexts.
// Checks done_o as well when AES_DONE_PULSE_EN is defined.
module tb_new_aes128_core;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         load_i;
    logic [127:0] key_i;
    logic [127:0] data_i;
    logic [127:0] data_o;
    logic         busy_o;
`ifdef AES_DONE_PULSE_EN
    logic         done_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q [$];

    new_aes128_core dut (
        .clk    (clk),
        .rst_i  (rst_i),
        .load_i (load_i),
        .key_i  (key_i),
        .data_i (data_i),
        .data_o (data_o),
`ifdef AES_DONE_PULSE_EN
        .done_o (done_o),
`endif
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Called just after a negedge; drives one load pulse and confirms busy rose.
    task automatic start(input logic [127:0] k, input logic [127:0] d);
        key_i  = k;
        data_i = d;
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        check("busy_after_load", {127'b0, busy_o}, 128'd1);
    endtask

    // mode 0: plain, 1: extra load at busy cycle 5, 2: reset at busy cycle 4,
    // 3: load (k2,d2) raised in the last busy cycle and left high.
    task automatic finish(input string tag, input int mode, input int cnt0,
                          input logic [127:0] k2, input logic [127:0] d2);
        int  cnt     = cnt0;
        bit  done    = 1'b0;
        bit  aborted = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mode == 1 && cnt == 5) begin
                load_i = 1'b1; key_i = ~key_i; data_i = ~data_i;
            end
            if (mode == 3 && cnt == 10) begin
                load_i = 1'b1; key_i = k2; data_i = d2;
            end
            if (mode == 2 && cnt == 4) rst_i = 1'b1;
            @(negedge clk);
            if (mode == 1) load_i = 1'b0;
            if (mode == 2 && rst_i) begin
                rst_i = 1'b0;
                check({tag, "_abort_busy"}, {127'b0, busy_o}, 128'd0);
                check({tag, "_abort_data"}, data_o, 128'd0);
                aborted = 1'b1;
                break;
            end
            if (busy_o) cnt++;
            else begin
                done = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check({tag, "_no_timeout"}, {127'b0, done}, 128'd1);
            check({tag, "_busy_cycles"}, 128'(cnt), 128'd10);
`ifdef AES_DONE_PULSE_EN
            check({tag, "_done_pulse"}, {127'b0, done_o}, 128'd1);
`endif
            if (exp_q.size() == 0) check({tag, "_scoreboard_empty"}, 128'd1, 128'd0);
            else check({tag, "_ciphertext"}, data_o, exp_q.pop_front());
        end
    endtask

    initial begin
        rst_i  = 1'b1;
        load_i = 1'b0;
        key_i  = '0;
        data_i = '1;

        // Reset held while load toggles: nothing may start.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_data", data_o, 128'd0);
            check("rst_busy", {127'b0, busy_o}, 128'd0);
`ifdef AES_DONE_PULSE_EN
            check("rst_done", {127'b0, done_o}, 128'd0);
`endif
            load_i = ~load_i;
        end
        @(negedge clk);
        rst_i  = 1'b0;
        load_i = 1'b0;
        @(negedge clk);
        check("idle_busy", {127'b0, busy_o}, 128'd0);

        exp_q.push_back(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        start(128'h0, 128'h0);
        finish("zero", 0, 1, '0, '0);
        @(negedge clk);
        check("hold_zero", data_o, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
`ifdef AES_DONE_PULSE_EN
        check("done_one_cycle", {127'b0, done_o}, 128'd0);
`endif

        exp_q.push_back(128'h3f5b8cc9ea855a0afa7347d23e8d664e);
        start(128'h0, {128{1'b1}});
        finish("ones", 0, 1, '0, '0);

        exp_q.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        start(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
        finish("fips", 0, 1, '0, '0);

        exp_q.push_back(128'h3925841d02dc09fbdc118597196a0b32);
        start(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
        finish("busy_load", 1, 1, '0, '0);

        start(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
        finish("abort", 2, 1, '0, '0);
        exp_q.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        start(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
        finish("after_abort", 0, 1, '0, '0);

        // load held over several edges: only the sample that starts the run counts.
        exp_q.push_back(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        key_i  = '0;
        data_i = '0;
        load_i = 1'b1;
        @(negedge clk);
        data_i = '1;
        @(negedge clk);
        load_i = 1'b0;
        finish("held_load", 0, 2, '0, '0);

        // Load raised in the final busy cycle: refused there, taken one edge later.
        exp_q.push_back(128'h3f5b8cc9ea855a0afa7347d23e8d664e);
        start(128'h0, {128{1'b1}});
        finish("b2b_first", 3, 1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3243f6a8885a308d313198a2e0370734);
        exp_q.push_back(128'h3925841d02dc09fbdc118597196a0b32);
        @(negedge clk);
        load_i = 1'b0;
        check("b2b_accepted", {127'b0, busy_o}, 128'd1);
        finish("b2b_second", 0, 1, '0, '0);

        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
